// File: rtl/slave_port.sv
// Bus-side slave: selects on the upper address bits, deserialises LSB-first write data,
// serialises read data from a local synchronous memory and handshakes via b_slv_rdy.
module slave_port #(
  parameter int ADDRESS_WIDTH  = 14,
  parameter int DATA_WIDTH     = 8,
  parameter int SLAVE_ID_WIDTH = 2,
  parameter int SLAVE_ID       = 0,
  localparam int MEM_ADDR_WIDTH = ADDRESS_WIDTH - SLAVE_ID_WIDTH
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [ADDRESS_WIDTH-1:0]  b_addrs,
  input  logic                      b_rd_wrt,
  input  logic                      b_bus_utilizing,
  inout  wire                       b_dinout,
  output wire                       b_slv_rdy,
  output logic [MEM_ADDR_WIDTH-1:0] s_addrs,
  output logic [DATA_WIDTH-1:0]     s_dout,
  output logic                      s_wr_en,
  output logic                      s_rd_en,
  input  logic [DATA_WIDTH-1:0]     s_din,
  output logic                      s_busy
);

  localparam int IDXW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DATA_WIDTH - 1);
  localparam logic [SLAVE_ID_WIDTH-1:0] MY_ID = SLAVE_ID_WIDTH'(SLAVE_ID);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_RX    = 3'd1,
    WR_ACK   = 3'd2,
    RD_REQ   = 3'd3,
    RD_LOAD  = 3'd4,
    RD_TX    = 3'd5,
    WAIT_REL = 3'd6
  } state_t;

  state_t state, next_state;

  logic [IDXW-1:0]           indx;
  logic [DATA_WIDTH-1:0]     shreg;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;

  logic util;
  logic sel;
  logic rdy_en;
  logic rdy_val;
  logic dout_en;

  // A floating or undriven bus-utilizing line counts as "not owned".
  assign util = (b_bus_utilizing == 1'b1);
  assign sel  = util && (b_addrs[ADDRESS_WIDTH-1 -: SLAVE_ID_WIDTH] == MY_ID);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (sel) next_state = b_rd_wrt ? WR_RX : RD_REQ;
      end
      WR_RX: begin
        if (!util)                 next_state = IDLE;
        else if (indx == LAST_IDX) next_state = WR_ACK;
      end
      WR_ACK:  next_state = WAIT_REL;
      RD_REQ:  next_state = util ? RD_LOAD : IDLE;
      RD_LOAD: next_state = util ? RD_TX : IDLE;
      RD_TX: begin
        if (!util)                 next_state = IDLE;
        else if (indx == LAST_IDX) next_state = WAIT_REL;
      end
      WAIT_REL: begin
        if (!util) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    s_wr_en = 1'b0;
    s_rd_en = 1'b0;
    rdy_en  = 1'b1;
    rdy_val = 1'b0;
    dout_en = 1'b0;
    case (state)
      IDLE:     rdy_en = 1'b0;
      WR_ACK: begin
        s_wr_en = 1'b1;
        rdy_val = 1'b1;
      end
      RD_REQ:   s_rd_en = 1'b1;
      RD_TX: begin
        rdy_val = 1'b1;
        dout_en = 1'b1;
      end
      default: ;
    endcase
  end

  assign s_busy    = (state != IDLE);
  assign b_slv_rdy = rdy_en  ? rdy_val     : 1'bz;
  assign b_dinout  = dout_en ? shreg[indx] : 1'bz;

  // Serial datapath: one shift register serves both directions; indx saturates at the last bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      indx   <= '0;
      shreg  <= '0;
      addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel) begin
            addr_q <= b_addrs[MEM_ADDR_WIDTH-1:0];
            if (b_rd_wrt) begin
              shreg[0] <= b_dinout;
              indx     <= IDXW'(1);
            end
          end
        end
        WR_RX: begin
          if (util) begin
            shreg[indx] <= b_dinout;
            if (indx != LAST_IDX) indx <= indx + IDXW'(1);
          end
        end
        RD_LOAD: begin
          if (util) begin
            shreg <= s_din;
            indx  <= '0;
          end
        end
        RD_TX: begin
          if (util && (indx != LAST_IDX)) indx <= indx + IDXW'(1);
        end
        default: ;
      endcase
    end
  end

  assign s_addrs = addr_q;
  assign s_dout  = shreg;

endmodule

// File: tb/tb_slave_port.sv
// Directed bench for slave_port: a bus-master model drives transfers, a memory model
// answers local strobes, and a scoreboard queue checks every strobe and serial read byte.
module tb_slave_port;

  logic        clk;
  logic        rstn;
  logic [13:0] b_addrs;
  logic        b_rd_wrt;
  logic        b_bus_utilizing;
  logic        tb_drv_en;
  logic        tb_drv;
  wire         b_dinout;
  wire         b_slv_rdy;
  logic [11:0] s_addrs;
  logic [7:0]  s_dout;
  logic        s_wr_en;
  logic        s_rd_en;
  logic [7:0]  s_din;
  logic        s_busy;

  // Weak pull-ups make a released line observable as 1 in a two-state simulator.
  pullup (b_dinout);
  pullup (b_slv_rdy);
  assign b_dinout = tb_drv_en ? tb_drv : 1'bz;

  slave_port dut (
    .clk             (clk),
    .rstn            (rstn),
    .b_addrs         (b_addrs),
    .b_rd_wrt        (b_rd_wrt),
    .b_bus_utilizing (b_bus_utilizing),
    .b_dinout        (b_dinout),
    .b_slv_rdy       (b_slv_rdy),
    .s_addrs         (s_addrs),
    .s_dout          (s_dout),
    .s_wr_en         (s_wr_en),
    .s_rd_en         (s_rd_en),
    .s_din           (s_din),
    .s_busy          (s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_wr;
    logic [11:0] addr;
    logic [7:0]  data;
  } txn_t;

  txn_t       exp_q[$];
  logic [7:0] rd_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int wr_count    = 0;

  logic [7:0] mem [0:4095];

  always @(posedge clk) begin
    if (s_wr_en) mem[s_addrs] <= s_dout;
    if (s_rd_en) s_din <= mem[s_addrs];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic util, input logic [13:0] addr, input logic rw,
                               input logic en, input logic bit_val);
    b_bus_utilizing = util;
    b_addrs         = addr;
    b_rd_wrt        = rw;
    tb_drv_en       = en;
    tb_drv          = bit_val;
  endtask

  // Strobe monitor: every local strobe must match the oldest queued transaction.
  always @(negedge clk) begin
    if (s_wr_en === 1'b1 || s_rd_en === 1'b1) begin
      txn_t t;
      logic ok;
      ok = (exp_q.size() != 0) && (exp_q[0].is_wr == s_wr_en);
      checkOutput("strobe_expected", {31'd0, ok}, 32'd1);
      if (s_wr_en === 1'b1) wr_count++;
      if (exp_q.size() != 0) begin
        t = exp_q.pop_front();
        checkOutput("strobe_addr", {20'd0, s_addrs}, {20'd0, t.addr});
        if (t.is_wr) begin
          checkOutput("wr_data", {24'd0, s_dout}, {24'd0, t.data});
          checkOutput("wr_ack_rdy", {31'd0, b_slv_rdy}, 32'd1);
        end
      end
    end
  end

  task automatic bus_write(input logic [13:0] addr, input logic [7:0] data, input int hold);
    exp_q.push_back('{1'b1, addr[11:0], data});
    @(negedge clk) applyStimulus(1'b1, addr, 1'b1, 1'b1, data[0]);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      checkOutput("wr_rx_rdy", {31'd0, b_slv_rdy}, 32'd0);
      applyStimulus(1'b1, addr, 1'b1, 1'b1, data[i]);
    end
    @(negedge clk);
    checkOutput("wr_ack_busy", {31'd0, s_busy}, 32'd1);
    applyStimulus(1'b1, addr, 1'b1, 1'b0, 1'b0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput("wait_rel_rdy", {31'd0, b_slv_rdy}, 32'd0);
      checkOutput("wait_rel_busy", {31'd0, s_busy}, 32'd1);
    end
    applyStimulus(1'b0, addr, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("idle_after_drop", {31'd0, s_busy}, 32'd0);
    checkOutput("idle_rdy_released", {31'd0, b_slv_rdy}, 32'd1);
  endtask

  task automatic wait_rd_tx(output int waited, output logic found);
    found  = 1'b0;
    waited = 0;
    while (!found && waited < 8) begin
      @(negedge clk);
      waited++;
      if (s_busy === 1'b1 && b_slv_rdy === 1'b1) found = 1'b1;
    end
    checkOutput("rd_tx_reached", {31'd0, found}, 32'd1);
  endtask

  task automatic bus_read(input logic [13:0] addr, input logic [7:0] data);
    int waited;
    logic found;
    logic [7:0] exp_byte;
    exp_q.push_back('{1'b0, addr[11:0], data});
    rd_q.push_back(data);
    @(negedge clk) applyStimulus(1'b1, addr, 1'b0, 1'b0, 1'b0);
    wait_rd_tx(waited, found);
    checkOutput("rd_latency", waited, 32'd3);
    exp_byte = rd_q.pop_front();
    if (found) begin
      for (int i = 0; i < 8; i++) begin
        if (i > 0) @(negedge clk);
        checkOutput($sformatf("rd_bit%0d", i), {31'd0, b_dinout}, {31'd0, exp_byte[i]});
        checkOutput("rd_tx_rdy", {31'd0, b_slv_rdy}, 32'd1);
      end
      @(negedge clk);
      checkOutput("rd_wait_rel_rdy", {31'd0, b_slv_rdy}, 32'd0);
    end
    applyStimulus(1'b0, addr, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("rd_idle_after_drop", {31'd0, s_busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    logic found;
    logic [7:0] abort_data;
    logic [7:0] nsel_data;
    logic [7:0] rst_byte;

    for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
    mem[12'h0FF] = 8'h3C;
    s_din = 8'h00;
    rstn  = 1'b0;
    applyStimulus(1'b0, 14'h0000, 1'b0, 1'b0, 1'b0);

    // Reset state
    #12;
    checkOutput("rst_busy", {31'd0, s_busy}, 32'd0);
    checkOutput("rst_wr_en", {31'd0, s_wr_en}, 32'd0);
    checkOutput("rst_rd_en", {31'd0, s_rd_en}, 32'd0);
    checkOutput("rst_addrs", {20'd0, s_addrs}, 32'd0);
    checkOutput("rst_dout", {24'd0, s_dout}, 32'd0);
    checkOutput("rst_rdy_released", {31'd0, b_slv_rdy}, 32'd1);
    @(negedge clk) rstn = 1'b1;
    @(negedge clk);

    // Write with the bus held five cycles past the acknowledge: exactly one strobe
    bus_write(14'h0123, 8'hA5, 5);
    checkOutput("held_bus_one_strobe", wr_count, 32'd1);
    bus_write(14'h0456, 8'h96, 1);

    // Reads, including data written above via the memory model
    bus_read(14'h00FF, 8'h3C);
    bus_read(14'h0456, 8'h96);

    // Not selected: slave ID 1
    nsel_data = 8'h5A;
    @(negedge clk) applyStimulus(1'b1, 14'h1123, 1'b1, 1'b1, nsel_data[0]);
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      checkOutput("nsel_busy", {31'd0, s_busy}, 32'd0);
      checkOutput("nsel_rdy_released", {31'd0, b_slv_rdy}, 32'd1);
      applyStimulus(1'b1, 14'h1123, 1'b1, 1'b1, nsel_data[i % 8]);
    end
    applyStimulus(1'b0, 14'h1123, 1'b1, 1'b0, 1'b0);
    @(negedge clk);

    // Abort after four write bits
    abort_data = 8'hC3;
    @(negedge clk) applyStimulus(1'b1, 14'h0222, 1'b1, 1'b1, abort_data[0]);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk) applyStimulus(1'b1, 14'h0222, 1'b1, 1'b1, abort_data[i]);
    end
    @(negedge clk);
    checkOutput("abort_busy_before_drop", {31'd0, s_busy}, 32'd1);
    applyStimulus(1'b0, 14'h0222, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("abort_idle", {31'd0, s_busy}, 32'd0);
    checkOutput("abort_rdy_released", {31'd0, b_slv_rdy}, 32'd1);
    repeat (10) @(negedge clk);
    checkOutput("abort_no_strobe", wr_count, 32'd2);

    // Reset in the middle of a serial read of 0x123 (A5: bits 1,0,1,...)
    exp_q.push_back('{1'b0, 12'h123, 8'hA5});
    rd_q.push_back(8'hA5);
    @(negedge clk) applyStimulus(1'b1, 14'h0123, 1'b0, 1'b0, 1'b0);
    wait_rd_tx(waited, found);
    rst_byte = rd_q.pop_front();
    checkOutput("rst_rd_bit0", {31'd0, b_dinout}, {31'd0, rst_byte[0]});
    @(negedge clk);
    checkOutput("rst_rd_bit1", {31'd0, b_dinout}, {31'd0, rst_byte[1]});
    rstn = 1'b0;
    #1;
    checkOutput("midrst_busy", {31'd0, s_busy}, 32'd0);
    checkOutput("midrst_dinout_released", {31'd0, b_dinout}, 32'd1);
    checkOutput("midrst_rdy_released", {31'd0, b_slv_rdy}, 32'd1);
    applyStimulus(1'b0, 14'h0000, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("post_rst_busy", {31'd0, s_busy}, 32'd0);
    checkOutput("final_wr_count", wr_count, 32'd2);
    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
